// File: rtl/dual_cam_pkg.sv
// rtl/dual_cam_pkg.sv - shared state encoding and default geometry for the dual camera line framer
package dual_cam_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int DEF_LINE_LEN    = 1280;
   localparam int DEF_START_LEVEL = 64;
   localparam int DEF_MIN_GAP     = 4;
   localparam int DEF_FIFO_AW     = 11;

   localparam int PIX_W = 11;
   localparam int GAP_W = 8;

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane synchronous FIFO, non-show-ahead: q updates the cycle after a read
module lane_fifo #(
   parameter int AW = 11,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr,
   input  logic [DW-1:0] wdata,
   input  logic          rd,
   output logic [DW-1:0] q,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   usedw
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;

   // Writes into a full FIFO are dropped even if a read frees a slot the same cycle.
   assign full  = (usedw == (AW+1)'(DEPTH));
   assign empty = (usedw == '0);
   assign wr_ok = wr && !full;
   assign rd_ok = rd && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usedw  <= '0;
         q      <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
            q      <= mem[rd_ptr];
         end
         case ({wr_ok, rd_ok})
            2'b10:   usedw <= usedw + (AW+1)'(1);
            2'b01:   usedw <= usedw - (AW+1)'(1);
            default: usedw <= usedw;
         endcase
      end
   end

endmodule

// File: rtl/dual_cam_line_framer.sv
// rtl/dual_cam_line_framer.sv - buffers two camera lanes and emits them as aligned, gap-separated lines
module dual_cam_line_framer
   import dual_cam_pkg::*;
#(
   parameter int LINE_LEN    = DEF_LINE_LEN,
   parameter int START_LEVEL = DEF_START_LEVEL,
   parameter int MIN_GAP     = DEF_MIN_GAP,
   parameter int FIFO_AW     = DEF_FIFO_AW
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] cam_data_0,
   input  logic [7:0] cam_data_1,
   input  logic       cam_valid_0,
   input  logic       cam_valid_1,
   input  logic       err_clr,
   output logic [7:0] raw_data_0,
   output logic [7:0] raw_data_1,
   output logic       raw_data_valid,
   output logic       raw_data_sop,
   output logic       raw_data_eop,
   output logic       underflow_err,
   output logic       overflow_err
);

   localparam logic [FIFO_AW:0] START_LVL = (FIFO_AW+1)'(START_LEVEL);
   localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(LINE_LEN);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

   state_t           state;
   logic [PIX_W-1:0] pix_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic [7:0]       q_0, q_1;
   logic             full_0, full_1;
   logic             empty_0, empty_1;
   logic [FIFO_AW:0] usedw_0, usedw_1;

   logic             start_ok;
   logic             rd_req;
   logic             uf_ev;
   logic             of_ev;
   logic             got_0, got_1;

   lane_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo_0 (
      .clk(clk), .reset_n(reset_n),
      .wr(cam_valid_0), .wdata(cam_data_0),
      .rd(rd_req), .q(q_0),
      .full(full_0), .empty(empty_0), .usedw(usedw_0)
   );

   lane_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo_1 (
      .clk(clk), .reset_n(reset_n),
      .wr(cam_valid_1), .wdata(cam_data_1),
      .rd(rd_req), .q(q_1),
      .full(full_1), .empty(empty_1), .usedw(usedw_1)
   );

   // Pixel 1 is read in the ARM cycle that sees both lanes ready, so ARM costs no extra gap.
   assign start_ok = (usedw_0 >= START_LVL) && (usedw_1 >= START_LVL);
   assign rd_req   = (state == STREAM) || ((state == ARM) && start_ok);
   assign uf_ev    = rd_req && (empty_0 || empty_1);
   assign of_ev    = (cam_valid_0 && full_0) || (cam_valid_1 && full_1);

   assign raw_data_0 = got_0 ? q_0 : 8'h00;
   assign raw_data_1 = got_1 ? q_1 : 8'h00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         pix_cnt        <= '0;
         gap_cnt        <= '0;
         raw_data_valid <= 1'b0;
         raw_data_sop   <= 1'b0;
         raw_data_eop   <= 1'b0;
         got_0          <= 1'b0;
         got_1          <= 1'b0;
         underflow_err  <= 1'b0;
         overflow_err   <= 1'b0;
      end else begin
         raw_data_valid <= rd_req;
         raw_data_sop   <= rd_req && (state == ARM);
         raw_data_eop   <= (state == STREAM) && (pix_cnt == LAST_PIX);
         got_0          <= rd_req && !empty_0;
         got_1          <= rd_req && !empty_1;
         underflow_err  <= uf_ev || (underflow_err && !err_clr);
         overflow_err   <= of_ev || (overflow_err && !err_clr);

         case (state)
            IDLE: begin
               if (gap_cnt != '1)
                  gap_cnt <= gap_cnt + GAP_W'(1);
               if (gap_cnt >= GAP_LAST)
                  state <= ARM;
            end
            ARM: begin
               if (start_ok) begin
                  state   <= STREAM;
                  pix_cnt <= PIX_W'(2);
               end
            end
            STREAM: begin
               if (pix_cnt == LAST_PIX) begin
                  state   <= IDLE;
                  pix_cnt <= '0;
                  gap_cnt <= '0;
               end else begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dual_cam_line_framer.sv
// tb/tb_dual_cam_line_framer.sv - randomized bench against a queue-based line scheduling model
module tb_dual_cam_line_framer;

   localparam int LINE_LEN    = 1280;
   localparam int START_LEVEL = 64;
   localparam int MIN_GAP     = 4;
   localparam int FIFO_AW     = 11;
   localparam int DEPTH       = 1 << FIFO_AW;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] cam_data_0 = '0, cam_data_1 = '0;
   logic       cam_valid_0 = 1'b0, cam_valid_1 = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] raw_data_0, raw_data_1;
   logic       raw_data_valid, raw_data_sop, raw_data_eop;
   logic       underflow_err, overflow_err;

   always #5 clk = ~clk;

   dual_cam_line_framer #(
      .LINE_LEN(LINE_LEN), .START_LEVEL(START_LEVEL), .MIN_GAP(MIN_GAP), .FIFO_AW(FIFO_AW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cam_data_0(cam_data_0), .cam_data_1(cam_data_1),
      .cam_valid_0(cam_valid_0), .cam_valid_1(cam_valid_1),
      .err_clr(err_clr),
      .raw_data_0(raw_data_0), .raw_data_1(raw_data_1),
      .raw_data_valid(raw_data_valid), .raw_data_sop(raw_data_sop), .raw_data_eop(raw_data_eop),
      .underflow_err(underflow_err), .overflow_err(overflow_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: each lane is a queue; a line may begin MIN_GAP cycles after the previous line's
   // last read (or reset release) once both queues hold START_LEVEL words, then reads run
   // LINE_LEN cycles straight, substituting 0 for any empty lane.
   logic [7:0] q0[$], q1[$];
   int  cyc, idle_start, pix;
   bit  in_line, e_uf, e_of;

   int  n_valid, n_eop, run, low_run, last_len, last_gap, first_out;
   bit  seen_eop;

   task automatic model_clear();
      q0.delete(); q1.delete();
      cyc = 0; idle_start = 0; pix = 0; in_line = 0; e_uf = 0; e_of = 0;
      n_valid = 0; n_eop = 0; run = 0; low_run = 0; last_len = -1; last_gap = -1;
      first_out = -1; seen_eop = 0;
   endtask

   task automatic step(input bit v0, input bit v1, input bit clr);
      logic [7:0] d0, d1, x0, x1;
      int  s0, s1;
      bit  rd, uf_ev, of_ev, ev, es, ee;
      d0 = 8'($urandom); d1 = 8'($urandom);
      cam_valid_0 = v0; cam_data_0 = d0;
      cam_valid_1 = v1; cam_data_1 = d1;
      err_clr = clr;
      s0 = q0.size(); s1 = q1.size();
      rd = in_line || (cyc >= idle_start + MIN_GAP && s0 >= START_LEVEL && s1 >= START_LEVEL);
      ev = 0; es = 0; ee = 0; x0 = '0; x1 = '0; uf_ev = 0; of_ev = 0;
      if (rd) begin
         if (!in_line) begin in_line = 1; pix = 1; end
         ev = 1; es = (pix == 1); ee = (pix == LINE_LEN);
         if (s0 > 0) x0 = q0.pop_front(); else uf_ev = 1;
         if (s1 > 0) x1 = q1.pop_front(); else uf_ev = 1;
         if (pix == LINE_LEN) begin in_line = 0; idle_start = cyc + 1; end
         else pix++;
      end
      if (v0) begin if (s0 < DEPTH) q0.push_back(d0); else of_ev = 1; end
      if (v1) begin if (s1 < DEPTH) q1.push_back(d1); else of_ev = 1; end
      e_uf = uf_ev | (e_uf & ~clr);
      e_of = of_ev | (e_of & ~clr);
      @(posedge clk); #1;
      cyc++;
      chk("cycle", {raw_data_valid, raw_data_sop, raw_data_eop, raw_data_0, raw_data_1,
                    underflow_err, overflow_err},
                   {ev, es, ee, x0, x1, e_uf, e_of});
      if (raw_data_valid) begin
         if (raw_data_sop) begin
            if (seen_eop) last_gap = low_run;
            run = 0;
         end
         run++; n_valid++;
         if (raw_data_eop) begin last_len = run; seen_eop = 1; n_eop++; end
         if (first_out < 0) first_out = cyc;
         low_run = 0;
      end else begin
         low_run++;
      end
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1 chk("reset_out", {raw_data_valid, raw_data_sop, raw_data_eop, raw_data_0, raw_data_1,
                           underflow_err, overflow_err}, '0);
      cam_valid_0 = 1'b0; cam_valid_1 = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      model_clear();
   endtask

   initial begin
      int eop_before;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("por_out", {raw_data_valid, raw_data_sop, raw_data_eop, raw_data_0, raw_data_1,
                      underflow_err, overflow_err}, '0);
      reset_n = 1'b1;

      // Continuous lanes, lane 1 delayed 32 cycles: first output 2 cycles after its 64th word.
      for (int c = 0; c < 2800; c++) step(1'b1, c >= 32, 1'b0);
      chk("first_valid", first_out, 32 + START_LEVEL - 1 + 2);
      chk("line_len", last_len, LINE_LEN);
      chk("line_gap", last_gap, 4);
      chk("line_count", n_eop, 2);

      // Lane 1 runs dry after 100 words mid-line.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         step(1'b1, c < 100, (c == 800) || (c == 1450));
         if (c == 800)  chk("uf_clr_vs_event", underflow_err, 1'b1);
         if (c == 1400) chk("uf_sticky", underflow_err, 1'b1);
         if (c == 1450) chk("uf_cleared", underflow_err, 1'b0);
      end
      chk("uf_line_len", last_len, LINE_LEN);

      // Lane 0 overfills with no reads possible.
      do_reset();
      for (int c = 0; c < 2100; c++) step(1'b1, 1'b0, 1'b0);
      chk("of_set", overflow_err, 1'b1);
      chk("of_no_line", n_valid, 0);
      step(1'b0, 1'b0, 1'b1);
      chk("of_cleared", overflow_err, 1'b0);

      // Reset at pixel 600 aborts the line; framing resumes cleanly afterwards.
      do_reset();
      for (int c = 0; c < 2000 && n_valid < 600; c++) step(1'b1, 1'b1, 1'b0);
      chk("abort_reach", n_valid, 600);
      eop_before = n_eop;
      do_reset();
      chk("abort_no_eop", eop_before, 0);
      for (int c = 0; c < 1500; c++) step(1'b1, 1'b1, 1'b0);
      chk("abort_first_valid", first_out, START_LEVEL + 1);
      chk("abort_relined", last_len, LINE_LEN);

      // Random lane duty and error clears.
      do_reset();
      for (int c = 0; c < 4000; c++)
         step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0);
      chk("rand_saw_line", n_eop > 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dual_cam_line_framer.md
DUAL_CAM_LINE_FRAMER -- requirements
Module: dual_cam_line_framer

Interface
REQ-001 SHALL have parameter LINE_LEN, default 1280, pixels per output line.
REQ-002 SHALL have parameter START_LEVEL, default 64, minimum words in each lane FIFO before a line starts.
REQ-003 SHALL have parameter MIN_GAP, default 4, minimum valid-low cycles between output lines.
REQ-004 SHALL have parameter FIFO_AW, default 11, lane FIFO address width (depth 2048).
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports cam_data_0 / cam_data_1  in  8  camera pixel per lane.
REQ-008 SHALL have ports cam_valid_0 / cam_valid_1  in  1  pixel strobe per lane.
REQ-009 SHALL have port err_clr  in  1  clears sticky error flags.
REQ-010 SHALL have ports raw_data_0 / raw_data_1  out  8  aligned lane pixels.
REQ-011 SHALL have ports raw_data_valid, raw_data_sop, raw_data_eop  out  1 each  line framing.
REQ-012 SHALL have ports underflow_err, overflow_err  out  1 each  sticky error flags.

Function
REQ-013 SHALL write cam_data_N into lane-N FIFO on every cycle cam_valid_N is high and lane-N FIFO is not full; writes while full are dropped and set overflow_err.
REQ-014 SHALL implement states IDLE, ARM, STREAM.
REQ-015 IDLE: gap counter increments from 0, saturating; IDLE -> ARM once gap counter reaches MIN_GAP.
REQ-016 ARM: ARM -> STREAM when both lane FIFO fill levels >= START_LEVEL.
REQ-017 STREAM: issue one read request per cycle to each lane for exactly LINE_LEN cycles, tracked by an 11-bit pixel counter 1..LINE_LEN; STREAM -> IDLE after read LINE_LEN; gap counter restarts at 0.
REQ-018 SHALL register outputs: FIFO data and framing appear 1 cycle after the corresponding read request.
REQ-019 raw_data_valid SHALL be high for exactly LINE_LEN contiguous cycles per line, never interrupted.
REQ-020 raw_data_sop SHALL be high only with pixel 1; raw_data_eop only with pixel LINE_LEN; sop and eop never with valid low.
REQ-021 Lane empty at a STREAM read: SHALL suppress that lane's read, output 8'h00 for that pixel, set underflow_err, and continue the line without gap; the other lane reads normally.
REQ-022 Simultaneous write and read on one lane SHALL both take effect; fill level unchanged.
REQ-023 err_clr SHALL clear both flags next cycle; a same-cycle new error event SHALL win (flag stays set).
REQ-024 raw_data_0/1 SHALL be 8'h00 whenever raw_data_valid is low.

Reset
REQ-025 reset_n low SHALL asynchronously force state IDLE, counters 0, both FIFOs empty, all outputs 0, both error flags 0.
REQ-026 Reset asserted mid-line SHALL abort the line with no eop; after release the first line starts only after MIN_GAP cycles and START_LEVEL refill.

Structure
REQ-027 Shared package dual_cam_pkg SHALL hold the state enum (IDLE, ARM, STREAM) and default constants LINE_LEN, START_LEVEL, MIN_GAP, FIFO_AW.
REQ-028 SHALL instantiate sub-module lane_fifo (synchronous, non-show-ahead, async reset, full/empty/usedw) twice, one per lane.
REQ-029 Pixel and gap counters and the FSM SHALL live in the top module; no combinational path from cam inputs to outputs.

Verification
REQ-030 Both lanes stream continuously, lane 1 starting 32 cycles after lane 0 -> first valid 2 cycles after lane 1 reaches 64 words, 1280 contiguous valid, sop on pixel 1, eop on pixel 1280, both lanes' pixel k output together.
REQ-031 Lane 1 stops after 100 words mid-line -> pixels 101..1280 on lane 1 are 8'h00, valid stays contiguous, underflow_err = 1 until err_clr.
REQ-032 Lane 0 writes 2100 words with no reads (lane 1 idle) -> words beyond 2048 dropped, overflow_err = 1, no output line.
REQ-033 Back-to-back full lines available -> exactly 4 valid-low cycles between eop and next sop (MIN_GAP + 0 ARM wait + pipeline).
REQ-034 reset_n pulsed low at pixel 600 -> outputs 0 immediately, no eop; after release and refill, next line has full sop..eop framing.
REQ-035 err_clr and new underflow in same cycle -> underflow_err stays 1.
